// File: rtl/i2c_bus_arbiter_if.sv
// Client and engine side signals of the shared I2C master arbiter.
// master: the arbiter's view; slave: the view of the clients and engine driving it.
interface i2c_bus_arbiter_if #(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]   req;
  logic [7*NUM_REQ-1:0] req_dev;
  logic [8*NUM_REQ-1:0] req_reg;
  logic [NUM_REQ-1:0]   req_rw;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           rsp_data;
  logic [1:0]           rsp_err;

  logic                 eng_start;
  logic [6:0]           eng_dev;
  logic [7:0]           eng_reg;
  logic                 eng_rw;
  logic [7:0]           eng_wdata;
  logic                 eng_abort;
  logic                 eng_done;
  logic                 eng_nack;
  logic [7:0]           eng_rdata;

  modport master (
    input  req, req_dev, req_reg, req_rw, req_wdata,
    output gnt, done, rsp_data, rsp_err,
    output eng_start, eng_dev, eng_reg, eng_rw, eng_wdata, eng_abort,
    input  eng_done, eng_nack, eng_rdata
  );

  modport slave (
    output req, req_dev, req_reg, req_rw, req_wdata,
    input  gnt, done, rsp_data, rsp_err,
    input  eng_start, eng_dev, eng_reg, eng_rw, eng_wdata, eng_abort,
    output eng_done, eng_nack, eng_rdata
  );

endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master engine among NUM_REQ clients.
//
// state  | meaning
// IDLE   | waiting for any req; picks the winner and latches its command
// LAUNCH | eng_start pulse, transaction timer cleared
// WAIT   | engine busy; ends on eng_done or abort at TIMEOUT-1
// RESP   | done pulse to the winner, grant released, rotation pointer updated
module i2c_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 24000
) (
  input  logic            clk,
  input  logic            rst,
  i2c_bus_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW    = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, winner_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [TW-1:0]      timer_q;
  logic [7:0]         rsp_data_q;
  logic [1:0]         rsp_err_q;
  logic [6:0]         eng_dev_q;
  logic [7:0]         eng_reg_q;
  logic               eng_rw_q;
  logic [7:0]         eng_wdata_q;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     cand;
  logic               timer_expired;

  // Scan starts one past the previous winner so every requester gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ))
        cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!pick_valid && bus.req[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign timer_expired = (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Strobes decode straight from state so a reset clears them without waiting for a clock.
  always_comb begin
    state_d       = state_q;
    bus.eng_start = 1'b0;
    bus.eng_abort = 1'b0;
    bus.done      = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid)
          state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        bus.eng_start = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_done) begin
          state_d = S_RESP;
        end else if (timer_expired) begin
          bus.eng_abort = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        bus.done = gnt_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= IDX_W'(NUM_REQ - 1);
      winner_q    <= '0;
      gnt_q       <= '0;
      timer_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
      eng_dev_q   <= '0;
      eng_reg_q   <= '0;
      eng_rw_q    <= 1'b0;
      eng_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            winner_q    <= pick_idx;
            gnt_q       <= NUM_REQ'(1) << pick_idx;
            eng_dev_q   <= bus.req_dev[int'(pick_idx)*7 +: 7];
            eng_reg_q   <= bus.req_reg[int'(pick_idx)*8 +: 8];
            eng_rw_q    <= bus.req_rw[pick_idx];
            eng_wdata_q <= bus.req_wdata[int'(pick_idx)*8 +: 8];
          end
        end
        S_LAUNCH: begin
          timer_q <= '0;
        end
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          // A completion in the final timer cycle still counts as a normal finish.
          if (bus.eng_done) begin
            rsp_data_q <= eng_rw_q ? bus.eng_rdata : 8'h00;
            rsp_err_q  <= bus.eng_nack ? 2'b01 : 2'b00;
          end else if (timer_expired) begin
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 2'b10;
          end
        end
        S_RESP: begin
          last_q <= winner_q;
          gnt_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.eng_dev   = eng_dev_q;
  assign bus.eng_reg   = eng_reg_q;
  assign bus.eng_rw    = eng_rw_q;
  assign bus.eng_wdata = eng_wdata_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level model of round-robin grant and response rules.
module tb_i2c_bus_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 100;

  logic clk;
  logic rst;

  i2c_bus_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  i2c_bus_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] f_dev   [NREQ];
  logic [7:0] f_reg   [NREQ];
  logic       f_rw    [NREQ];
  logic [7:0] f_wdata [NREQ];

  int         mlast;
  logic [6:0] hold_dev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < NREQ; i++) begin
      f_dev[i]   = 7'($urandom);
      f_reg[i]   = 8'($urandom);
      f_rw[i]    = 1'($urandom);
      f_wdata[i] = 8'($urandom);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_dev[i*7 +: 7]   = f_dev[i];
      bus.req_reg[i*8 +: 8]   = f_reg[i];
      bus.req_rw[i]           = f_rw[i];
      bus.req_wdata[i*8 +: 8] = f_wdata[i];
    end
  endtask

  // One full transaction starting in an IDLE cycle. d = WAIT cycle of eng_done; d >= TMO means silent engine.
  task automatic do_txn(input logic [NREQ-1:0] reqv, input logic [NREQ-1:0] drop,
                        input int d, input logic nack, input logic [7:0] rdat);
    int              w;
    logic [NREQ-1:0] oh;
    logic [7:0]      exp_data;
    logic [1:0]      exp_err;
    @(negedge clk);
    bus.req = reqv;
    drive_fields();
    #1;
    chk("idle_gnt", 32'(bus.gnt), 0);
    chk("idle_start", 32'(bus.eng_start), 0);
    chk("eng_dev_hold", 32'(bus.eng_dev), 32'(hold_dev));
    w  = pick(reqv, mlast);
    oh = NREQ'(1) << w;

    @(negedge clk);
    #1;
    chk("gnt", 32'(bus.gnt), 32'(oh));
    chk("eng_start", 32'(bus.eng_start), 1);
    chk("eng_dev", 32'(bus.eng_dev), 32'(f_dev[w]));
    chk("eng_reg", 32'(bus.eng_reg), 32'(f_reg[w]));
    chk("eng_rw", 32'(bus.eng_rw), 32'(f_rw[w]));
    chk("eng_wdata", 32'(bus.eng_wdata), 32'(f_wdata[w]));
    bus.req = reqv & ~drop;

    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      if (k == d) begin
        bus.eng_done  = 1'b1;
        bus.eng_nack  = nack;
        bus.eng_rdata = rdat;
        #1;
        chk("abort_vs_done", 32'(bus.eng_abort), 0);
        break;
      end
      #1;
      if (k == TMO - 1) begin
        chk("abort_pulse", 32'(bus.eng_abort), 1);
        break;
      end
      if (k == 0 || k == TMO - 2) begin
        chk("wait_abort", 32'(bus.eng_abort), 0);
        chk("wait_done", 32'(bus.done), 0);
        chk("wait_start", 32'(bus.eng_start), 0);
      end
    end

    if (d < TMO) begin
      exp_err  = nack ? 2'b01 : 2'b00;
      exp_data = f_rw[w] ? rdat : 8'h00;
    end else begin
      exp_err  = 2'b10;
      exp_data = 8'h00;
    end

    @(negedge clk);
    bus.eng_done  = 1'b0;
    bus.eng_nack  = 1'b0;
    bus.eng_rdata = 8'($urandom);
    #1;
    chk("done", 32'(bus.done), 32'(oh));
    chk("gnt_at_done", 32'(bus.gnt), 32'(oh));
    chk("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    chk("done_abort", 32'(bus.eng_abort), 0);
    mlast    = w;
    hold_dev = f_dev[w];
  endtask

  // Idle cycles with no requests; optionally a stray eng_done that must be ignored.
  task automatic idle_cycles(input int n, input logic spurious);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req      = '0;
      bus.eng_done = spurious && (i == 0);
      #1;
      chk("idle_gnt_quiet", 32'(bus.gnt), 0);
      chk("idle_done_quiet", 32'(bus.done), 0);
      chk("idle_start_quiet", 32'(bus.eng_start), 0);
    end
    bus.eng_done = 1'b0;
  endtask

  initial begin
    int d;
    int sel;
    logic [NREQ-1:0] rv;
    logic [NREQ-1:0] dv;

    rst           = 1'b1;
    bus.req       = '0;
    bus.req_dev   = '0;
    bus.req_reg   = '0;
    bus.req_rw    = '0;
    bus.req_wdata = '0;
    bus.eng_done  = 1'b0;
    bus.eng_nack  = 1'b0;
    bus.eng_rdata = '0;
    mlast         = NREQ - 1;
    hold_dev      = '0;
    rand_fields();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_start", 32'(bus.eng_start), 0);
    chk("rst_abort", 32'(bus.eng_abort), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_eng_fields", {bus.eng_dev, bus.eng_reg, bus.eng_rw, bus.eng_wdata}, 0);
    @(negedge clk);
    rst = 1'b0;

    // All four held: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      do_txn(4'b1111, 4'b0000, 5 + i, 1'b0, 8'($urandom));
    end
    idle_cycles(3, 1'b1);

    // Single read on requester 0.
    rand_fields();
    f_dev[0] = 7'h50; f_reg[0] = 8'h0A; f_rw[0] = 1'b1;
    do_txn(4'b0001, 4'b0000, 39, 1'b0, 8'hA5);

    // Write on requester 2 answered with NACK.
    rand_fields();
    f_dev[2] = 7'h68; f_reg[2] = 8'h6B; f_rw[2] = 1'b0; f_wdata[2] = 8'h00;
    do_txn(4'b0100, 4'b0000, 12, 1'b1, 8'h3C);

    // Silent engine: abort after TMO cycles.
    rand_fields();
    do_txn(4'b1000, 4'b0000, TMO + 10, 1'b0, 8'h00);

    // Completion on the very last timer cycle beats the abort.
    rand_fields();
    do_txn(4'b0010, 4'b0000, TMO - 1, 1'b1, 8'h77);

    // Requester 1 drops mid-transaction: still completes, no regrant.
    rand_fields();
    do_txn(4'b0010, 4'b0010, 20, 1'b0, 8'h99);
    idle_cycles(4, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rand_fields();
      rv  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      dv  = ($urandom_range(0, 3) == 0) ? (rv & NREQ'($urandom)) : '0;
      sel = $urandom_range(0, 9);
      if (sel < 7)       d = $urandom_range(0, 60);
      else if (sel == 7) d = TMO - 1;
      else if (sel == 8) d = TMO - 2;
      else               d = TMO + 5;
      do_txn(rv, dv, d, 1'($urandom), 8'($urandom));
      if ($urandom_range(0, 4) == 0)
        idle_cycles(2, 1'($urandom));
    end

    // Reset in the middle of WAIT.
    @(negedge clk);
    rand_fields();
    bus.req = 4'b0100;
    drive_fields();
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(bus.gnt), 0);
    chk("midrst_start", 32'(bus.eng_start), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_abort", 32'(bus.eng_abort), 0);
    chk("midrst_eng_dev", 32'(bus.eng_dev), 0);
    mlast    = NREQ - 1;
    hold_dev = '0;
    @(negedge clk);
    bus.req = '0;
    rst     = 1'b0;
    rand_fields();
    do_txn(4'b1000, 4'b0000, 8, 1'b0, 8'h11);
    rand_fields();
    do_txn(4'b1111, 4'b0000, 8, 1'b0, 8'h22);
    idle_cycles(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
